obj_ext_ram_arbiter: RTL

OBJ_EXT_RAM_ARBITER -- requirements
Module: obj_ext_ram_arbiter

---
 rtl/obj_ext_ram_arbiter_if.sv | 50 +++++
 rtl/obj_ext_ram_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/obj_ext_ram_arbiter_if.sv
// rtl/obj_ext_ram_arbiter_if.sv - object/CPU/save-state requester and extension RAM bus bundle
interface obj_ext_ram_arbiter_if;
  logic        obj_req;
  logic [11:0] obj_addr;
  logic        obj_ready;
  logic        obj_valid;
  logic [7:0]  obj_q;

  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_q;

  logic        ss_req;
  logic        ss_we;
  logic [11:0] ss_addr;
  logic [7:0]  ss_wdata;
  logic        ss_ack;
  logic [7:0]  ss_q;

  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_q;

  // master: requesters plus the RAM itself; slave: the arbiter
  modport master (
    output obj_req, obj_addr,
    input  obj_ready, obj_valid, obj_q,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_q,
    output ss_req, ss_we, ss_addr, ss_wdata,
    input  ss_ack, ss_q,
    input  ram_addr, ram_we, ram_wdata,
    output ram_q
  );

  modport slave (
    input  obj_req, obj_addr,
    output obj_ready, obj_valid, obj_q,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_q,
    input  ss_req, ss_we, ss_addr, ss_wdata,
    output ss_ack, ss_q,
    output ram_addr, ram_we, ram_wdata,
    input  ram_q
  );
endinterface

// File: rtl/obj_ext_ram_arbiter.sv
// rtl/obj_ext_ram_arbiter.sv - three-way arbiter onto a single-port 4096x8 extension RAM
// Object lookups win over CPU, CPU over save-state; CPU is forced ahead after STARVE_LIMIT lost cycles.
module obj_ext_ram_arbiter #(
  parameter int STARVE_LIMIT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  obj_ext_ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {SRC_OBJ, SRC_CPU, SRC_SS} src_t;

  logic [CW-1:0] r_cnt;
  logic          r_obj_ready;
  logic          r_s1_vld, r_s2_vld;
  src_t          r_s1_src, r_s2_src;
  logic          r_s1_we,  r_s2_we;
  logic          r_obj_valid, r_cpu_ack, r_ss_ack;
  logic [7:0]    r_obj_q, r_cpu_q, r_ss_q;
  logic [11:0]   r_ram_addr;
  logic          r_ram_we;
  logic [7:0]    r_ram_wdata;

  logic          w_cpu_busy, w_ss_busy;
  logic          w_cpu_elig, w_ss_elig;
  logic          w_grant_obj, w_grant_cpu, w_grant_ss, w_grant_any;
  logic [CW-1:0] w_cnt_next;
  logic [11:0]   w_addr;
  logic [7:0]    w_wdata;
  logic          w_we;

  // A requester still in the pipe or acking this cycle must not be granted again
  assign w_cpu_busy = (r_s1_vld && r_s1_src == SRC_CPU) || (r_s2_vld && r_s2_src == SRC_CPU);
  assign w_ss_busy  = (r_s1_vld && r_s1_src == SRC_SS)  || (r_s2_vld && r_s2_src == SRC_SS);
  assign w_cpu_elig = bus.cpu_req && !w_cpu_busy && !r_cpu_ack;
  assign w_ss_elig  = bus.ss_req  && !w_ss_busy  && !r_ss_ack;

  // obj_ready low is the forced-CPU cycle: dropping the object leaves CPU on top
  assign w_grant_obj = bus.obj_req && r_obj_ready;
  assign w_grant_cpu = !w_grant_obj && w_cpu_elig;
  assign w_grant_ss  = !w_grant_obj && !w_cpu_elig && w_ss_elig;
  assign w_grant_any = w_grant_obj || w_grant_cpu || w_grant_ss;

  always_comb begin
    w_addr  = bus.obj_addr;
    w_wdata = 8'h00;
    w_we    = 1'b0;
    if (w_grant_cpu) begin
      w_addr  = bus.cpu_addr;
      w_wdata = bus.cpu_wdata;
      w_we    = bus.cpu_we;
    end else if (w_grant_ss) begin
      w_addr  = bus.ss_addr;
      w_wdata = bus.ss_wdata;
      w_we    = bus.ss_we;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (!bus.cpu_req || w_grant_cpu)
      w_cnt_next = '0;
    else if (w_cpu_elig && r_cnt != LIMIT)
      w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_obj_ready <= 1'b1;
      r_s1_vld    <= 1'b0;
      r_s1_src    <= SRC_OBJ;
      r_s1_we     <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s2_src    <= SRC_OBJ;
      r_s2_we     <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_obj_valid <= 1'b0;
      r_obj_q     <= '0;
      r_cpu_ack   <= 1'b0;
      r_cpu_q     <= '0;
      r_ss_ack    <= 1'b0;
      r_ss_q      <= '0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_obj_ready <= !(w_cnt_next == LIMIT && r_cnt != LIMIT);

      r_s1_vld <= w_grant_any;
      r_s1_src <= w_grant_obj ? SRC_OBJ : (w_grant_cpu ? SRC_CPU : SRC_SS);
      r_s1_we  <= w_grant_any && w_we;
      r_ram_we <= w_grant_any && w_we;
      if (w_grant_any) begin
        r_ram_addr  <= w_addr;
        r_ram_wdata <= w_wdata;
      end

      r_s2_vld <= r_s1_vld;
      r_s2_src <= r_s1_src;
      r_s2_we  <= r_s1_we;

      // ram_q now holds the byte for the address captured two edges ago
      r_obj_valid <= r_s2_vld && r_s2_src == SRC_OBJ;
      r_cpu_ack   <= r_s2_vld && r_s2_src == SRC_CPU;
      r_ss_ack    <= r_s2_vld && r_s2_src == SRC_SS;
      if (r_s2_vld && r_s2_src == SRC_OBJ) r_obj_q <= bus.ram_q;
      if (r_s2_vld && r_s2_src == SRC_CPU) r_cpu_q <= r_s2_we ? 8'h00 : bus.ram_q;
      if (r_s2_vld && r_s2_src == SRC_SS)  r_ss_q  <= r_s2_we ? 8'h00 : bus.ram_q;
    end
  end

  assign bus.obj_ready = r_obj_ready;
  assign bus.obj_valid = r_obj_valid;
  assign bus.obj_q     = r_obj_q;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_q     = r_cpu_q;
  assign bus.ss_ack    = r_ss_ack;
  assign bus.ss_q      = r_ss_q;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_wdata = r_ram_wdata;

endmodule
